// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with CPU register window (data, status, count, control)
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic       rx_data_ready,
    input  logic       cs,
    input  logic       R_W_n,
    input  logic [1:0] reg_addr,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       rx_avail
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  prev_rd_q, prev_rd_d;
    logic                  rx_avail_q, rx_avail_d;

    logic full, empty, rd_access, ctrl_wr, flush, clr_ovf, pop, push, push_en, ovf_set;
    logic unused_data_i;

    assign unused_data_i = ^data_i[7:2];
    assign rx_data_ready = 1'b1;
    assign rx_avail      = rx_avail_q;

    assign full      = (count_q == COUNT_FULL);
    assign empty     = (count_q == '0);
    assign rd_access = cs & R_W_n & (reg_addr == 2'd0);
    assign ctrl_wr   = cs & ~R_W_n & (reg_addr == 2'd3);
    assign flush     = ctrl_wr & data_i[0];
    assign clr_ovf   = ctrl_wr & data_i[1];
    // A held read pops only on its first cycle.
    assign pop       = rd_access & ~prev_rd_q & ~empty;
    assign push      = rx_data_valid & (~full | pop);
    assign push_en   = push & ~flush;
    assign ovf_set   = rx_data_valid & full & ~pop & ~flush;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        prev_rd_d  = rd_access;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
        // Setting wins over a same-cycle clear so no overflow event is lost.
        if (ovf_set)
            overflow_d = 1'b1;
        else if (clr_ovf)
            overflow_d = 1'b0;
        rx_avail_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            prev_rd_q  <= 1'b0;
            rx_avail_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            prev_rd_q  <= prev_rd_d;
            rx_avail_q <= rx_avail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_en)
            mem_q[wr_ptr_q] <= rx_data;
    end

    always_comb begin
        data_o = 8'h00;
        case (reg_addr)
            2'd0: data_o = empty ? 8'h00 : mem_q[rd_ptr_q];
            2'd1: data_o = {overflow_q, full, 5'b0, ~empty};
            2'd2: data_o = 8'(count_q);
            default: data_o = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized and directed checks of uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic       rx_data_ready;
    logic       cs = 1'b0;
    logic       R_W_n = 1'b1;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic       rx_avail;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready), .cs(cs), .R_W_n(R_W_n), .reg_addr(reg_addr),
        .data_i(data_i), .data_o(data_o), .rx_avail(rx_avail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_prev = 1'b0;
    logic       m_avail = 1'b0;
    logic [7:0] last_do;

    task automatic expect_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return (mq.size() > 0) ? mq[0] : 8'h00;
            2'd1: return {m_ovf, mq.size() == DEPTH, 5'b0, mq.size() != 0};
            2'd2: return 8'(mq.size());
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_update(input logic r, v, input logic [7:0] d,
                                input logic c, rw, input logic [1:0] a, input logic [7:0] di);
        logic rd, fl, clr, set;
        rd  = c && rw && (a == 2'd0);
        fl  = c && !rw && (a == 2'd3) && di[0];
        clr = c && !rw && (a == 2'd3) && di[1];
        set = 1'b0;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0; m_prev = 1'b0; m_avail = 1'b0;
        end else begin
            if (fl) begin
                mq.delete();
            end else begin
                if (rd && !m_prev && mq.size() > 0)
                    void'(mq.pop_front());
                if (v) begin
                    if (mq.size() < DEPTH) mq.push_back(d);
                    else set = 1'b1;
                end
            end
            if (set) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_prev  = rd;
            m_avail = (mq.size() != 0);
        end
    endtask

    // Entered at a negedge; applies one cycle of inputs and checks both read data and rx_avail.
    task automatic step(input logic r, v, input logic [7:0] d,
                        input logic c, rw, input logic [1:0] a, input logic [7:0] di);
        rst = r; rx_data_valid = v; rx_data = d; cs = c; R_W_n = rw; reg_addr = a; data_i = di;
        #1;
        last_do = data_o;
        if (!r) expect_eq("data_o", data_o, model_read(a));
        model_update(r, v, d, c, rw, a, di);
        @(posedge clk);
        #1;
        expect_eq("rx_avail", {7'b0, rx_avail}, {7'b0, m_avail});
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00);
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b0, 1'b1, b, 1'b0, 1'b1, 2'd0, 8'h00);
    endtask

    task automatic ctrl_write(input logic [7:0] v);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd3, v);
    endtask

    task automatic read_expect(input string tag, input logic [1:0] a, input logic [7:0] exp);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, a, 8'h00);
        expect_eq(tag, last_do, exp);
        idle();
    endtask

    initial begin
        @(negedge clk);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h00);
        expect_eq("ready", {7'b0, rx_data_ready}, 8'h01);
        read_expect("reset_status", 2'd1, 8'h00);
        read_expect("reset_count", 2'd2, 8'h00);

        push(8'h41); push(8'h42); push(8'h43);
        read_expect("abc_count", 2'd2, 8'h03);
        read_expect("abc_status", 2'd1, 8'h01);
        read_expect("abc_0", 2'd0, 8'h41);
        read_expect("abc_1", 2'd0, 8'h42);
        read_expect("abc_2", 2'd0, 8'h43);
        read_expect("abc_empty", 2'd2, 8'h00);
        expect_eq("abc_avail", {7'b0, rx_avail}, 8'h00);

        push(8'hA0); push(8'hA1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 8'h00);
            if (i == 0) expect_eq("hold_first", last_do, 8'hA0);
        end
        idle();
        read_expect("hold_count", 2'd2, 8'h01);
        read_expect("hold_rest", 2'd0, 8'hA1);

        for (int i = 0; i <= 16; i++) push(8'(i));
        read_expect("ovf_count", 2'd2, 8'h10);
        read_expect("ovf_status", 2'd1, 8'hC1);
        for (int i = 0; i < 16; i++) read_expect("ovf_drain", 2'd0, 8'(i));
        ctrl_write(8'h02);
        read_expect("ovf_clear", 2'd1, 8'h00);

        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 2'd0, 8'h00);
        expect_eq("fullpop_head", last_do, 8'h20);
        idle();
        read_expect("fullpop_status", 2'd1, 8'h41);
        read_expect("fullpop_count", 2'd2, 8'h10);
        for (int i = 1; i < 16; i++) read_expect("fullpop_drain", 2'd0, 8'h20 + 8'(i));
        read_expect("fullpop_new", 2'd0, 8'h99);

        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 2'd3, 8'h01);
        read_expect("flush_count", 2'd2, 8'h00);
        read_expect("flush_status", 2'd1, 8'h00);
        read_expect("flush_data", 2'd0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            push(8'h50 + 8'(i));
            if (i >= 3) read_expect("wrap_order", 2'd0, 8'h50 + 8'(i - 3));
        end
        for (int i = 17; i < 20; i++) read_expect("wrap_tail", 2'd0, 8'h50 + 8'(i));
        read_expect("wrap_status", 2'd1, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            logic r, v, c, rw;
            logic [1:0] a;
            logic [7:0] d, di;
            r  = ($urandom % 400) == 0;
            v  = ($urandom % 3) == 0;
            d  = 8'($urandom);
            c  = ($urandom % 2) == 0;
            rw = ($urandom % 20) != 0;
            a  = 2'($urandom);
            di = 8'($urandom);
            step(r, v, d, c, rw, a, di);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
